// File: rtl/riscv_exec_pkg.sv
// Shared operation encodings and flag bit positions for the execute stage.
package riscv_exec_pkg;

    typedef enum logic [4:0] {
        OP_ADD   = 5'd0,
        OP_SUB   = 5'd1,
        OP_XOR   = 5'd2,
        OP_OR    = 5'd3,
        OP_AND   = 5'd4,
        OP_SLL   = 5'd5,
        OP_SRL   = 5'd6,
        OP_SRA   = 5'd7,
        OP_SLT   = 5'd8,
        OP_SLTU  = 5'd9,
        OP_LUI   = 5'd10,
        OP_AUIPC = 5'd11,
        OP_JAL   = 5'd12,
        OP_JALR  = 5'd13,
        OP_BEQ   = 5'd16,
        OP_BNE   = 5'd17,
        OP_BLT   = 5'd18,
        OP_BGE   = 5'd19,
        OP_BLTU  = 5'd20,
        OP_BGEU  = 5'd21
    } exec_op_t;

    // Bit positions inside the {N,Z,C,V} flag vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic is_branch(input logic [4:0] op);
        return (op >= 5'd16) && (op <= 5'd21);
    endfunction

    function automatic logic is_alu_op(input logic [4:0] op);
        return op <= 5'd9;
    endfunction

endpackage

// File: rtl/riscv_alu.sv
// Combinational integer ALU: arithmetic, logic, shifts and set-less-than with NZCV flags.
module riscv_alu
    import riscv_exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic [3:0]      flags
);

    localparam int SHW = $clog2(XLEN);

    exec_op_t        op_e;
    logic [XLEN:0]   sum;
    logic [XLEN:0]   diff;
    logic [SHW-1:0]  shamt;
    logic            lt_s;
    logic            lt_u;
    logic            c_flag;
    logic            v_flag;
    logic            nz_en;

    assign op_e  = exec_op_t'(op);
    assign sum   = {1'b0, a} + {1'b0, b};
    // Subtract as A + ~B + 1 so the carry-out reads as "no borrow"
    assign diff  = {1'b0, a} + {1'b0, ~b} + (XLEN+1)'(1);
    assign shamt = b[SHW-1:0];
    assign lt_s  = $signed(a) < $signed(b);
    assign lt_u  = a < b;

    always_comb begin
        result = '0;
        c_flag = 1'b0;
        v_flag = 1'b0;
        nz_en  = 1'b1;
        case (op_e)
            OP_ADD: begin
                result = sum[XLEN-1:0];
                c_flag = sum[XLEN];
                v_flag = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
            end
            OP_SUB: begin
                result = diff[XLEN-1:0];
                c_flag = diff[XLEN];
                v_flag = (a[XLEN-1] != b[XLEN-1]) && (diff[XLEN-1] != a[XLEN-1]);
            end
            OP_XOR:  result = a ^ b;
            OP_OR:   result = a | b;
            OP_AND:  result = a & b;
            OP_SLL:  result = a << shamt;
            OP_SRL:  result = a >> shamt;
            OP_SRA:  result = $signed(a) >>> shamt;
            OP_SLT:  result = {{(XLEN-1){1'b0}}, lt_s};
            OP_SLTU: result = {{(XLEN-1){1'b0}}, lt_u};
            default: nz_en  = 1'b0;
        endcase
    end

    always_comb begin
        flags         = '0;
        flags[FLAG_N] = nz_en && result[XLEN-1];
        flags[FLAG_Z] = nz_en && (result == '0);
        flags[FLAG_C] = c_flag;
        flags[FLAG_V] = v_flag;
    end

endmodule

// File: rtl/riscv_exec_stage.sv
// Single-cycle pipelined execute stage: operand select, ALU, jumps/branches,
// valid/ready output register with flush, and saturating retire/taken counters.
module riscv_exec_stage
    import riscv_exec_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [XLEN-1:0]   in_rs1,
    input  logic [XLEN-1:0]   in_rs2,
    input  logic [XLEN-1:0]   in_imm,
    input  logic              in_use_imm,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_wb_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_result,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_wb_en,
    output logic [3:0]        out_flags,
    output logic              out_redirect,
    output logic [XLEN-1:0]   out_target,
    output logic              out_misalign,
    output logic [CNT_W-1:0]  cnt_retired,
    output logic [CNT_W-1:0]  cnt_taken
);

    exec_op_t        op_e;
    logic [XLEN-1:0] opnd_b;
    logic [XLEN-1:0] alu_result;
    logic [3:0]      alu_flags;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pc_plus_imm;
    logic [XLEN-1:0] jalr_sum;
    logic            br_eq;
    logic            br_lt;
    logic            br_ltu;
    logic            br_taken;

    logic [XLEN-1:0] nxt_result;
    logic [3:0]      nxt_flags;
    logic            nxt_wb_ok;
    logic            nxt_redirect;
    logic [XLEN-1:0] nxt_target;

    logic            accept;
    logic            retire;

    assign op_e        = exec_op_t'(in_op);
    assign opnd_b      = in_use_imm ? in_imm : in_rs2;
    assign pc_plus4    = in_pc + XLEN'(4);
    assign pc_plus_imm = in_pc + in_imm;
    assign jalr_sum    = in_rs1 + in_imm;

    riscv_alu #(
        .XLEN (XLEN)
    ) u_alu (
        .op     (in_op),
        .a      (in_rs1),
        .b      (opnd_b),
        .result (alu_result),
        .flags  (alu_flags)
    );

    // Branches always compare the two register operands, never the immediate
    assign br_eq  = in_rs1 == in_rs2;
    assign br_lt  = $signed(in_rs1) < $signed(in_rs2);
    assign br_ltu = in_rs1 < in_rs2;

    always_comb begin
        br_taken = 1'b0;
        case (op_e)
            OP_BEQ:  br_taken = br_eq;
            OP_BNE:  br_taken = !br_eq;
            OP_BLT:  br_taken = br_lt;
            OP_BGE:  br_taken = !br_lt;
            OP_BLTU: br_taken = br_ltu;
            OP_BGEU: br_taken = !br_ltu;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        nxt_result   = alu_result;
        nxt_flags    = alu_flags;
        nxt_wb_ok    = 1'b1;
        nxt_redirect = 1'b0;
        nxt_target   = '0;
        if (is_branch(in_op)) begin
            nxt_result   = '0;
            nxt_flags    = '0;
            nxt_wb_ok    = 1'b0;
            nxt_redirect = br_taken;
            nxt_target   = br_taken ? pc_plus_imm : '0;
        end else if (!is_alu_op(in_op)) begin
            nxt_flags = '0;
            case (op_e)
                OP_LUI:   nxt_result = in_imm;
                OP_AUIPC: nxt_result = pc_plus_imm;
                OP_JAL: begin
                    nxt_result   = pc_plus4;
                    nxt_redirect = 1'b1;
                    nxt_target   = pc_plus_imm;
                end
                OP_JALR: begin
                    nxt_result   = pc_plus4;
                    nxt_redirect = 1'b1;
                    nxt_target   = {jalr_sum[XLEN-1:1], 1'b0};
                end
                default: begin
                    nxt_result = '0;
                    nxt_wb_ok  = 1'b0;
                end
            endcase
        end
    end

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    // A flushed output beat is discarded, so it does not count as retired
    assign retire   = out_valid && out_ready && !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_rd       <= '0;
            out_wb_en    <= 1'b0;
            out_flags    <= '0;
            out_redirect <= 1'b0;
            out_target   <= '0;
            out_misalign <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            out_result   <= nxt_result;
            out_rd       <= in_rd;
            out_wb_en    <= in_wb_en && nxt_wb_ok && (in_rd != '0);
            out_flags    <= nxt_flags;
            out_redirect <= nxt_redirect;
            out_target   <= nxt_target;
            out_misalign <= nxt_redirect && nxt_target[1];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_retired <= '0;
            cnt_taken   <= '0;
        end else if (retire) begin
            if (cnt_retired != '1) cnt_retired <= cnt_retired + CNT_W'(1);
            if (out_redirect && (cnt_taken != '1)) cnt_taken <= cnt_taken + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_riscv_exec_stage.sv
// Self-checking bench for riscv_exec_stage: directed scenarios plus a randomized run
// against a behavioural reference model.
module tb_riscv_exec_stage;
    import riscv_exec_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_op = '0;
    logic [31:0] in_rs1 = '0, in_rs2 = '0, in_imm = '0, in_pc = '0;
    logic        in_use_imm = 1'b0;
    logic [4:0]  in_rd = '0;
    logic        in_wb_en = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result, out_target;
    logic [4:0]  out_rd;
    logic        out_wb_en, out_redirect, out_misalign;
    logic [3:0]  out_flags;
    logic [15:0] cnt_retired, cnt_taken;

    logic        s_in_ready, s_out_valid, s_out_wb_en, s_out_redirect, s_out_misalign;
    logic [31:0] s_out_result, s_out_target;
    logic [4:0]  s_out_rd;
    logic [3:0]  s_out_flags;
    logic [3:0]  s_cnt_retired, s_cnt_taken;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        wb_en;
        logic [3:0]  flags;
        logic        redirect;
        logic [31:0] target;
        logic        misalign;
    } beat_t;

    always #5 clk = ~clk;

    riscv_exec_stage #(.XLEN(32), .REG_AW(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .in_pc(in_pc), .in_rd(in_rd), .in_wb_en(in_wb_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_wb_en(out_wb_en), .out_flags(out_flags),
        .out_redirect(out_redirect), .out_target(out_target), .out_misalign(out_misalign),
        .cnt_retired(cnt_retired), .cnt_taken(cnt_taken)
    );

    riscv_exec_stage #(.XLEN(32), .REG_AW(5), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .in_pc(in_pc), .in_rd(in_rd), .in_wb_en(in_wb_en),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_result(s_out_result),
        .out_rd(s_out_rd), .out_wb_en(s_out_wb_en), .out_flags(s_out_flags),
        .out_redirect(s_out_redirect), .out_target(s_out_target), .out_misalign(s_out_misalign),
        .cnt_retired(s_cnt_retired), .cnt_taken(s_cnt_taken)
    );

    function automatic beat_t ref_exec(input logic [4:0] op, input logic [31:0] rs1, rs2, imm,
                                       input logic use_imm, input logic [31:0] pc,
                                       input logic [4:0] rd, input logic wb);
        beat_t          r;
        logic [31:0]    a, b;
        longint         sa, sb, s;
        longint unsigned ua, ub;
        int             sh;
        logic           is_br, known, taken, arith;
        r = '0;
        a = rs1;
        b = use_imm ? imm : rs2;
        sa = $signed(a); sb = $signed(b);
        ua = a; ub = b;
        sh = int'(b & 32'd31);
        is_br = 1'b0; known = 1'b1; taken = 1'b0; arith = 1'b1;
        case (op)
            5'd0: begin
                r.result = a + b;
                s = sa + sb;
                r.flags[1] = (ua + ub) > 64'hFFFF_FFFF;
                r.flags[0] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            5'd1: begin
                r.result = a - b;
                s = sa - sb;
                r.flags[1] = ua >= ub;
                r.flags[0] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            5'd2: r.result = a ^ b;
            5'd3: r.result = a | b;
            5'd4: r.result = a & b;
            5'd5: r.result = a << sh;
            5'd6: r.result = a >> sh;
            5'd7: r.result = $signed(a) >>> sh;
            5'd8: r.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd9: r.result = (a < b) ? 32'd1 : 32'd0;
            5'd10: begin arith = 1'b0; r.result = imm; end
            5'd11: begin arith = 1'b0; r.result = pc + imm; end
            5'd12: begin arith = 1'b0; r.result = pc + 32'd4; taken = 1'b1; r.target = pc + imm; end
            5'd13: begin arith = 1'b0; r.result = pc + 32'd4; taken = 1'b1; r.target = (rs1 + imm) & ~32'd1; end
            5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21: begin
                arith = 1'b0; is_br = 1'b1;
                case (op)
                    5'd16:   taken = rs1 == rs2;
                    5'd17:   taken = rs1 != rs2;
                    5'd18:   taken = $signed(rs1) < $signed(rs2);
                    5'd19:   taken = $signed(rs1) >= $signed(rs2);
                    5'd20:   taken = rs1 < rs2;
                    default: taken = rs1 >= rs2;
                endcase
                if (taken) r.target = pc + imm;
            end
            default: begin arith = 1'b0; known = 1'b0; end
        endcase
        if (arith) begin
            r.flags[3] = r.result[31];
            r.flags[2] = (r.result == 32'd0);
        end
        r.rd       = rd;
        r.redirect = taken;
        r.wb_en    = wb && known && !is_br && (rd != 5'd0);
        r.misalign = taken && r.target[1];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] rs1, rs2, imm,
                         input logic use_imm, input logic [31:0] pc, input logic [4:0] rd,
                         input logic wb);
        in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_use_imm = use_imm;
        in_pc = pc; in_rd = rd; in_wb_en = wb; in_valid = 1'b1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] rs1, rs2, imm,
                         input logic use_imm, input logic [31:0] pc, input logic [4:0] rd,
                         input logic wb);
        drive(op, rs1, rs2, imm, use_imm, pc, rd, wb);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        issue(OP_JAL, 0, 0, 32'h10, 0, 32'h8, 5'd1, 1);
        issue(OP_ADD, 3, 4, 0, 0, 0, 5'd2, 1);
        out_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, out_result, out_rd, out_wb_en, out_flags, out_redirect, out_target, out_misalign} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got valid=%b result=%h rd=%0d wb=%b flags=%b redir=%b target=%h mis=%b, want all 0",
                     out_valid, out_result, out_rd, out_wb_en, out_flags, out_redirect, out_target, out_misalign);
        end
        n_cmp++;
        if (cnt_retired !== 16'd0 || cnt_taken !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_counters: got retired=%0d taken=%0d, want 0/0", cnt_retired, cnt_taken);
        end
        #2 rst = 1'b1;
        step();
    endtask

    task automatic test_add();
        drive(OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h0, 0, 0, 5'd1, 1);
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL add_latency: got out_valid=%b before edge, want 0", out_valid);
        end
        step();
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_result !== 32'h8000_0000 || out_flags !== 4'b1001 || out_wb_en !== 1'b1) begin
            n_bad++;
            $display("FAIL add_overflow: got valid=%b result=%h flags=%b wb=%b, want 1 80000000 1001 1",
                     out_valid, out_result, out_flags, out_wb_en);
        end
    endtask

    task automatic test_sub();
        issue(OP_SUB, 5, 5, 0, 0, 0, 5'd3, 1);
        n_cmp++;
        if (out_result !== 32'h0 || out_flags !== 4'b0110) begin
            n_bad++;
            $display("FAIL sub_equal: got result=%h flags=%b, want 00000000 0110", out_result, out_flags);
        end
        issue(OP_SUB, 0, 1, 0, 0, 0, 5'd3, 1);
        n_cmp++;
        if (out_result !== 32'hFFFF_FFFF || out_flags !== 4'b1000) begin
            n_bad++;
            $display("FAIL sub_borrow: got result=%h flags=%b, want ffffffff 1000", out_result, out_flags);
        end
    endtask

    task automatic test_shift_jalr();
        issue(OP_SRA, 32'h8000_0000, 32'h1, 32'h24, 1, 0, 5'd4, 1);
        n_cmp++;
        if (out_result !== 32'hF800_0000 || out_flags !== 4'b1000) begin
            n_bad++;
            $display("FAIL sra_imm: got result=%h flags=%b, want f8000000 1000", out_result, out_flags);
        end
        issue(OP_JALR, 32'h203, 32'h0, 32'h0, 0, 32'h100, 5'd1, 1);
        n_cmp++;
        if (out_result !== 32'h104 || out_target !== 32'h202 || out_redirect !== 1'b1 ||
            out_misalign !== 1'b1 || out_wb_en !== 1'b1) begin
            n_bad++;
            $display("FAIL jalr: got result=%h target=%h redir=%b mis=%b wb=%b, want 104 202 1 1 1",
                     out_result, out_target, out_redirect, out_misalign, out_wb_en);
        end
    endtask

    task automatic test_branch();
        issue(OP_BLT, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFF8, 1, 32'h40, 5'd5, 1);
        n_cmp++;
        if (out_redirect !== 1'b1 || out_target !== 32'h38 || out_wb_en !== 1'b0 || out_result !== 32'h0) begin
            n_bad++;
            $display("FAIL blt_taken: got redir=%b target=%h wb=%b result=%h, want 1 38 0 0",
                     out_redirect, out_target, out_wb_en, out_result);
        end
        issue(OP_BLTU, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFF8, 1, 32'h40, 5'd5, 1);
        n_cmp++;
        if (out_redirect !== 1'b0 || out_wb_en !== 1'b0 || out_misalign !== 1'b0) begin
            n_bad++;
            $display("FAIL bltu_not_taken: got redir=%b wb=%b mis=%b, want 0 0 0", out_redirect, out_wb_en, out_misalign);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(OP_ADD, 10, 20, 0, 0, 0, 5'd2, 1);
        out_ready = 1'b0;
        step();
        drive(OP_ADD, 1, 1, 0, 0, 0, 5'd3, 1);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_result !== 32'd30 || out_rd !== 5'd2 || in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL stall_hold[%0d]: got valid=%b result=%0d rd=%0d in_ready=%b, want 1 30 2 0",
                         i, out_valid, out_result, out_rd, in_ready);
            end
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        n_cmp++;
        if (out_valid !== 1'b0 || cnt_retired !== 16'd1) begin
            n_bad++;
            $display("FAIL stall_release: got valid=%b retired=%0d, want 0 1", out_valid, cnt_retired);
        end
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(OP_ADD, 32'd100, 32'(k * 3), 0, 0, 0, 5'd6, 1);
            step();
            n_cmp++;
            if (out_valid !== 1'b1 || out_result !== 32'(100 + k * 3)) begin
                n_bad++;
                $display("FAIL b2b[%0d]: got valid=%b result=%0d, want 1 %0d", k, out_valid, out_result, 100 + k * 3);
            end
        end
        in_valid = 1'b0;
        step();
        n_cmp++;
        if (out_valid !== 1'b0 || cnt_retired !== 16'd4) begin
            n_bad++;
            $display("FAIL b2b_count: got valid=%b retired=%0d, want 0 4", out_valid, cnt_retired);
        end
        drive(OP_ADD, 1, 2, 0, 0, 0, 5'd1, 1);
        flush = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_ready: got in_ready=%b, want 1", in_ready);
        end
        step();
        flush = 1'b0; in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || cnt_retired !== 16'd4) begin
            n_bad++;
            $display("FAIL flush_drop: got valid=%b retired=%0d, want 0 4", out_valid, cnt_retired);
        end
        drive(OP_ADD, 7, 8, 0, 0, 0, 5'd1, 1);
        out_ready = 1'b0;
        step();
        drive(OP_ADD, 9, 9, 0, 0, 0, 5'd1, 1);
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        n_cmp++;
        if (out_valid !== 1'b0 || cnt_retired !== 16'd4) begin
            n_bad++;
            $display("FAIL flush_held: got valid=%b retired=%0d, want 0 4", out_valid, cnt_retired);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(OP_JAL, 0, 0, 32'h8, 0, 32'(i * 4), 5'd1, 1);
            step();
        end
        in_valid = 1'b0;
        step();
        n_cmp++;
        if (s_cnt_retired !== 4'd15 || s_cnt_taken !== 4'd15) begin
            n_bad++;
            $display("FAIL sat_small: got retired=%0d taken=%0d, want 15 15", s_cnt_retired, s_cnt_taken);
        end
        n_cmp++;
        if (cnt_retired !== 16'd20 || cnt_taken !== 16'd20) begin
            n_bad++;
            $display("FAIL sat_wide: got retired=%0d taken=%0d, want 20 20", cnt_retired, cnt_taken);
        end
        issue(OP_ADD, 5, 0, 7, 1, 0, 5'd0, 1);
        n_cmp++;
        if (out_wb_en !== 1'b0 || out_result !== 32'd12) begin
            n_bad++;
            $display("FAIL addi_rd0: got wb=%b result=%0d, want 0 12", out_wb_en, out_result);
        end
    endtask

    task automatic test_unknown();
        do_reset();
        issue(5'd14, 32'h1234, 32'h5678, 32'h40, 1, 32'h100, 5'd7, 1);
        n_cmp++;
        if (out_valid !== 1'b1 || out_result !== 32'h0 || out_flags !== 4'b0 ||
            out_wb_en !== 1'b0 || out_redirect !== 1'b0) begin
            n_bad++;
            $display("FAIL unknown_op: got valid=%b result=%h flags=%b wb=%b redir=%b, want 1 0 0 0 0",
                     out_valid, out_result, out_flags, out_wb_en, out_redirect);
        end
        step();
        n_cmp++;
        if (cnt_retired !== 16'd1 || cnt_taken !== 16'd0) begin
            n_bad++;
            $display("FAIL unknown_count: got retired=%0d taken=%0d, want 1 0", cnt_retired, cnt_taken);
        end
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [4:0] ops[24] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                                5'd10, 5'd11, 5'd12, 5'd13, 5'd16, 5'd17, 5'd18, 5'd19,
                                5'd20, 5'd21, 5'd14, 5'd15, 5'd22, 5'd31};
        beat_t       m_beat, nb, got;
        logic        m_valid, fire, acc;
        int          m_ret, m_tak, ms_ret, ms_tak;
        do_reset();
        m_valid = 1'b0; m_beat = '0;
        m_ret = 0; m_tak = 0; ms_ret = 0; ms_tak = 0;
        for (int c = 0; c < 400; c++) begin
            drive(ops[$urandom_range(0, 23)], rnd32(), rnd32(), rnd32(), 1'($urandom_range(0, 1)),
                  rnd32(), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            #3;
            n_cmp++;
            if (in_ready !== (!m_valid || out_ready)) begin
                n_bad++;
                $display("FAIL rnd_in_ready[%0d]: got %b want %b", c, in_ready, !m_valid || out_ready);
            end
            fire = m_valid && out_ready;
            acc  = in_valid && (!m_valid || out_ready);
            nb   = ref_exec(in_op, in_rs1, in_rs2, in_imm, in_use_imm, in_pc, in_rd, in_wb_en);
            step();
            if (fire) begin
                if (m_ret < 65535) m_ret++;
                if (ms_ret < 15) ms_ret++;
                if (m_beat.redirect) begin
                    if (m_tak < 65535) m_tak++;
                    if (ms_tak < 15) ms_tak++;
                end
            end
            if (acc) begin
                m_valid = 1'b1;
                m_beat  = nb;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            n_cmp++;
            if (out_valid !== m_valid) begin
                n_bad++;
                $display("FAIL rnd_valid[%0d]: got %b want %b", c, out_valid, m_valid);
            end
            if (m_valid) begin
                got = {out_result, out_rd, out_wb_en, out_flags, out_redirect, out_target, out_misalign};
                n_cmp++;
                if (got !== m_beat) begin
                    n_bad++;
                    $display("FAIL rnd_beat[%0d] op=%0d: got res=%h rd=%0d wb=%b fl=%b rd=%b tg=%h mis=%b want res=%h rd=%0d wb=%b fl=%b rd=%b tg=%h mis=%b",
                             c, in_op, got.result, got.rd, got.wb_en, got.flags, got.redirect, got.target, got.misalign,
                             m_beat.result, m_beat.rd, m_beat.wb_en, m_beat.flags, m_beat.redirect, m_beat.target, m_beat.misalign);
                end
            end
            n_cmp++;
            if (cnt_retired !== 16'(m_ret) || cnt_taken !== 16'(m_tak) ||
                s_cnt_retired !== 4'(ms_ret) || s_cnt_taken !== 4'(ms_tak)) begin
                n_bad++;
                $display("FAIL rnd_counters[%0d]: got %0d/%0d small %0d/%0d want %0d/%0d small %0d/%0d",
                         c, cnt_retired, cnt_taken, s_cnt_retired, s_cnt_taken, m_ret, m_tak, ms_ret, ms_tak);
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_shift_jalr();
        test_branch();
        test_backpressure();
        test_saturation();
        test_unknown();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/riscv_exec_stage.md
Name: riscv_exec_stage

Overview:
- Parametrised execute stage for the team's RISC-V core, replacing the inline ALU, flag and branch logic with a standalone pipelined block.
- Sits between decode/register-read and writeback; consumes decoded operands and produces result, destination, flags and branch redirect.
- Adds three things the previous core lacked: a valid/ready handshake with backpressure, flush, and saturating retire/taken counters.

Parameters:
XLEN, 32, datapath width (32 or 64)
REG_AW, 5, destination register index width
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
flush  in  1  discard the output register and any input presented this cycle
in_valid  in  1  input beat valid
in_ready  out  1  stage can accept a beat
in_op  in  5  operation code, exec_op_t from the package
in_rs1  in  XLEN  rs1 value
in_rs2  in  XLEN  rs2 value
in_imm  in  XLEN  sign-extended immediate
in_use_imm  in  1  use in_imm as operand B instead of in_rs2 (ALU ops only)
in_pc  in  XLEN  PC of the instruction
in_rd  in  REG_AW  destination register
in_wb_en  in  1  instruction writes rd
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts the beat
out_result  out  XLEN  value to write to rd
out_rd  out  REG_AW  destination register
out_wb_en  out  1  write enable; forced 0 when rd==0 or op is a branch
out_flags  out  4  {N,Z,C,V}
out_redirect  out  1  beat carries a control transfer
out_target  out  XLEN  redirect PC
out_misalign  out  1  taken target has bit 1 set
cnt_retired  out  CNT_W  count of accepted output beats
cnt_taken  out  CNT_W  count of accepted beats with out_redirect=1

Behaviour:
- Reset (rst=0, asynchronous): all outputs are 0, including out_valid, both counters and the output register contents.
- Latency: one cycle. A beat accepted at edge k appears on out_* after edge k.
- Handshake:
  - in_ready = !out_valid || out_ready, with flush having no effect on in_ready.
  - A beat transfers when in_valid && in_ready.
  - The output holds stable while out_valid && !out_ready.
  - Back-to-back beats sustain full throughput.
- Flush: at the next edge out_valid becomes 0 and the input beat of that cycle is dropped. Flush wins over every simultaneous accept. Counters do not increment for a dropped beat.
- Operand B: in_imm when in_use_imm=1, otherwise in_rs2.
- Shifts (SLL, SRL, SRA) use B[$clog2(XLEN)-1:0] only; SRA is signed.
- Arithmetic and flags:
  - ADD and SUB are computed at XLEN+1 bits. SUB is A + ~B + 1.
  - C is the carry-out; for SUB, C=1 means no borrow.
  - V for ADD = (A[msb]==B[msb]) && (R[msb]!=A[msb]).
  - V for SUB = (A[msb]!=B[msb]) && (R[msb]!=A[msb]).
  - For logic ops, shifts and SLT/SLTU: C=V=0, and N/Z come from the result.
  - SLT is signed, SLTU unsigned; both produce 1 or 0.
- Upper-immediate ops: LUI result = imm; AUIPC result = pc + imm. Both set flags to 0 and redirect to 0.
- Jumps:
  - JAL: result = pc+4, target = pc+imm, redirect=1.
  - JALR: result = pc+4, target = (rs1+imm) & ~1, redirect=1.
- Branches:
  - BEQ, BNE, BLT, BGE, BLTU, BGEU compare rs1 with rs2; in_use_imm is ignored.
  - Taken branch: redirect=1, target = pc+imm.
  - Every branch: result=0 and out_wb_en=0.
- out_misalign = redirect && target[1]. The redirect is still reported; the trap is handled upstream.
- Unknown op: result=0, flags=0, wb_en=0, redirect=0, and the beat is still passed through and counted.
- All sums wrap modulo 2^XLEN.
- Counters:
  - cnt_retired increments on each out_valid && out_ready.
  - cnt_taken increments when that accepted beat also has out_redirect=1.
  - Both saturate at 2^CNT_W-1.

Decomposition:
- Package riscv_exec_pkg holds:
  - exec_op_t encodings: ADD=0, SUB=1, XOR=2, OR=3, AND=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9, LUI=10, AUIPC=11, JAL=12, JALR=13, BEQ=16, BNE=17, BLT=18, BGE=19, BLTU=20, BGEU=21.
  - Flag bit index constants.
- Sub-module riscv_alu is purely combinational: op, A and B in; result and flags out.
- riscv_exec_stage owns operand muxing, branch resolution, the output register, the handshake and the counters.

Test Plan:
- Reset and basic op: rst pulsed low mid-stream -> all outputs 0 immediately. Then ADD rs1=0x7FFFFFFF, rs2=1 -> result 0x80000000, flags N=1 Z=0 C=0 V=1, one cycle later.
- SUB: rs1=5, rs2=5 -> result 0, Z=1, C=1, V=0. rs1=0, rs2=1 -> result 0xFFFFFFFF, N=1, C=0.
- Shift and JALR: SRA rs1=0x80000000 with B=0x24 -> shift by 4 -> 0xF8000000. JALR pc=0x100, rs1=0x203, imm=0 -> result 0x104, target 0x202, misalign=1.
- Branches: BLT rs1=-1, rs2=1, pc=0x40, imm=-8 -> redirect=1, target 0x38, wb_en=0. BLTU with the same operands -> redirect=0.
- Backpressure and flush: out_ready held 0 for 3 cycles -> output stable and in_ready=0; then 4 back-to-back beats -> 4 outputs and cnt_retired=4. Flush asserted with in_valid=1 -> out_valid=0 next cycle and cnt_retired unchanged.
- Saturation: CNT_W=4 with 20 taken JALs -> cnt_taken=15 and cnt_retired=15; ADDI rd=0 -> out_wb_en=0.
